// File: rtl/mlp_pkg.sv
// Shared types, defaults and ROM address helpers for the O/X detection MLP.
package mlp_pkg;

  localparam int DEF_N_IN   = 16;
  localparam int DEF_N_HID  = 8;
  localparam int DEF_N_OUT  = 2;
  localparam int DEF_W_W    = 8;
  localparam int DEF_ACC_W  = 20;
  localparam int DEF_SHIFT  = 2;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H_RUN,
    ST_H_STORE,
    ST_O_RUN,
    ST_O_STORE,
    ST_DECIDE
  } state_t;

  typedef enum logic [2:0] {
    MAC_HOLD,
    MAC_CLR,
    MAC_BIAS,
    MAC_GATED,
    MAC_PROD
  } mac_mode_t;

  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,
    CLS_O    = 2'b01,
    CLS_X    = 2'b10
  } class_t;

  // Each hidden neuron occupies bias + one weight per input.
  function automatic int hid_base(input int h, input int n_in);
    return h * (n_in + 1);
  endfunction

  // Output neurons follow the hidden block: bias + one weight per hidden neuron.
  function automatic int out_base(input int o, input int n_in, input int n_hid);
    return n_hid * (n_in + 1) + o * (n_hid + 1);
  endfunction

endpackage

// File: rtl/mlp_infer_ctrl_if.sv
// Request/result handshake and weight ROM bus of the MLP inference controller.
interface mlp_infer_ctrl_if
  import mlp_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int W_W    = DEF_W_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                     start;
  logic [N_IN-1:0]          in_flags;
  logic                     w_rd_en;
  logic [ADDR_W-1:0]        w_addr;
  logic signed [W_W-1:0]    w_data;
  logic                     busy;
  logic                     done;
  logic [1:0]               result_class;
  logic signed [ACC_W-1:0]  score_o;
  logic signed [ACC_W-1:0]  score_x;

  // Controller side: takes requests and ROM data, drives ROM address and results.
  modport master (
    input  start, in_flags, w_data,
    output w_rd_en, w_addr, busy, done, result_class, score_o, score_x
  );

  // Environment side: requester, weight ROM and result consumer.
  modport slave (
    output start, in_flags, w_data,
    input  w_rd_en, w_addr, busy, done, result_class, score_o, score_x
  );

endinterface

// File: rtl/mlp_mac.sv
// Shared saturating accumulator: clear, add bias, flag-gated add, or add weight*activation.
module mlp_mac
  import mlp_pkg::*;
#(
  parameter int W_W   = DEF_W_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  mac_mode_t               mode,
  input  logic signed [W_W-1:0]   data,
  input  logic                    gate,
  input  logic [7:0]              act,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = W_W + 9;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [P_W-1:0]   data_ext;
  logic signed [P_W-1:0]   act_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] addend;
  logic [ACC_W:0]          sum_ext;
  logic signed [ACC_W-1:0] sum_sat;
  logic signed [ACC_W-1:0] acc_reg;

  always_comb begin
    data_ext = P_W'(data);
    act_ext  = P_W'({1'b0, act});
    prod     = data_ext * act_ext;
    addend   = '0;
    case (mode)
      MAC_BIAS:  addend = ACC_W'(data);
      MAC_GATED: addend = gate ? ACC_W'(data) : '0;
      // Activations never exceed 127, so the product always fits the accumulator.
      MAC_PROD:  addend = ACC_W'(prod);
      default:   addend = '0;
    endcase
    sum_ext = {acc_reg[ACC_W-1], acc_reg} + {addend[ACC_W-1], addend};
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
      sum_sat = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_sat = sum_ext[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else begin
      case (mode)
        MAC_CLR:                      acc_reg <= '0;
        MAC_BIAS, MAC_GATED, MAC_PROD: acc_reg <= sum_sat;
        default:                      ;
      endcase
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/mlp_infer_ctrl.sv
// Sequences one O/X MLP inference: hidden layer by flag-gated sums, output layer by
// weight*activation products, all through one shared MAC fed from the weight ROM.
module mlp_infer_ctrl
  import mlp_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_HID  = DEF_N_HID,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int W_W    = DEF_W_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SHIFT  = DEF_SHIFT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  mlp_infer_ctrl_if.master bus
);

  localparam int CNT_MAX = ((N_IN > N_HID) ? N_IN : N_HID) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int FLAG_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(N_IN);
  localparam logic [CNT_W-1:0] H_DRAIN = CNT_W'(N_IN + 1);
  localparam logic [CNT_W-1:0] O_LAST  = CNT_W'(N_HID);
  localparam logic [CNT_W-1:0] O_DRAIN = CNT_W'(N_HID + 1);
  localparam logic [IDX_W-1:0] IDX_H_LAST = IDX_W'(N_HID - 1);
  localparam logic [IDX_W-1:0] IDX_O_LAST = IDX_W'(N_OUT - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [N_IN-1:0]         flags_reg;
  logic [7:0]              act_reg [N_HID];
  logic [N_HID-1:0]        act_we_vec;
  logic signed [ACC_W-1:0] score_work_reg [N_OUT];

  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [FLAG_W-1:0]       flag_idx;
  logic [IDX_W-1:0]        act_idx;
  logic                    rd_valid_reg, rd_first_reg, rd_layer_reg, rd_gate_reg;
  logic [7:0]              rd_act_reg;

  logic                    accept, mac_clr, act_we, score_we, decide;
  mac_mode_t               mac_mode;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_shifted;
  logic [7:0]              act_val;
  logic [1:0]              class_calc;

  logic                    busy_reg, done_reg;
  logic [1:0]              class_reg;
  logic signed [ACC_W-1:0] score_o_reg, score_x_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rd_en      = 1'b0;
    rd_addr    = '0;
    accept     = 1'b0;
    mac_clr    = 1'b0;
    act_we     = 1'b0;
    score_we   = 1'b0;
    decide     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          mac_clr    = 1'b1;
          cnt_next   = '0;
          idx_next   = '0;
          state_next = ST_H_RUN;
        end
      end
      ST_H_RUN: begin
        rd_en = (cnt_reg <= H_LAST);
        if (rd_en) begin
          rd_addr = ADDR_W'(hid_base(int'(idx_reg), N_IN)) + ADDR_W'(cnt_reg);
        end
        if (cnt_reg == H_DRAIN) begin
          cnt_next   = '0;
          state_next = ST_H_STORE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_H_STORE: begin
        act_we  = 1'b1;
        mac_clr = 1'b1;
        if (idx_reg == IDX_H_LAST) begin
          idx_next   = '0;
          state_next = ST_O_RUN;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = ST_H_RUN;
        end
      end
      ST_O_RUN: begin
        rd_en = (cnt_reg <= O_LAST);
        if (rd_en) begin
          rd_addr = ADDR_W'(out_base(int'(idx_reg), N_IN, N_HID)) + ADDR_W'(cnt_reg);
        end
        if (cnt_reg == O_DRAIN) begin
          cnt_next   = '0;
          state_next = ST_O_STORE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_O_STORE: begin
        score_we = 1'b1;
        mac_clr  = 1'b1;
        if (idx_reg == IDX_O_LAST) begin
          idx_next   = '0;
          state_next = ST_DECIDE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = ST_O_RUN;
        end
      end
      ST_DECIDE: begin
        decide     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read slot k>0 addresses weight k-1; its gate flag or activation is captured
  // alongside the read so it lines up with w_data one cycle later.
  assign flag_idx = FLAG_W'(cnt_reg - CNT_W'(1));
  assign act_idx  = IDX_W'(cnt_reg - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_first_reg <= 1'b0;
      rd_layer_reg <= 1'b0;
      rd_gate_reg  <= 1'b0;
      rd_act_reg   <= '0;
      flags_reg    <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      rd_first_reg <= (cnt_reg == '0);
      rd_layer_reg <= (state_reg == ST_O_RUN);
      rd_gate_reg  <= flags_reg[flag_idx];
      rd_act_reg   <= act_reg[act_idx];
      if (accept) begin
        flags_reg <= bus.in_flags;
      end
    end
  end

  always_comb begin
    mac_mode = MAC_HOLD;
    if (mac_clr) begin
      mac_mode = MAC_CLR;
    end else if (rd_valid_reg) begin
      if (rd_first_reg)      mac_mode = MAC_BIAS;
      else if (rd_layer_reg) mac_mode = MAC_PROD;
      else                   mac_mode = MAC_GATED;
    end
  end

  mlp_mac #(
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .mode (mac_mode),
    .data (bus.w_data),
    .gate (rd_gate_reg),
    .act  (rd_act_reg),
    .acc  (acc)
  );

  // ReLU, scale down, then clamp into the 7-bit activation range.
  always_comb begin
    acc_shifted = acc >>> SHIFT;
    if (acc[ACC_W-1]) begin
      act_val = 8'd0;
    end else if (|acc_shifted[ACC_W-1:7]) begin
      act_val = 8'd127;
    end else begin
      act_val = acc_shifted[7:0];
    end
  end

  for (genvar gi = 0; gi < N_HID; gi++) begin : g_act_we
    assign act_we_vec[gi] = act_we && (idx_reg == IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_HID; i++) act_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_HID; i++) begin
        if (act_we_vec[i]) act_reg[i] <= act_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_OUT; i++) score_work_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (score_we && idx_reg == IDX_W'(i)) score_work_reg[i] <= acc;
      end
    end
  end

  always_comb begin
    class_calc = CLS_NONE;
    if (score_work_reg[0] > score_work_reg[1] &&
        !score_work_reg[0][ACC_W-1] && (|score_work_reg[0])) begin
      class_calc = CLS_O;
    end else if (score_work_reg[1] > score_work_reg[0] &&
                 !score_work_reg[1][ACC_W-1] && (|score_work_reg[1])) begin
      class_calc = CLS_X;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      class_reg   <= CLS_NONE;
      score_o_reg <= '0;
      score_x_reg <= '0;
    end else begin
      done_reg <= decide;
      if (decide) begin
        busy_reg    <= 1'b0;
        class_reg   <= class_calc;
        score_o_reg <= score_work_reg[0];
        score_x_reg <= score_work_reg[1];
      end else if (accept) begin
        busy_reg <= 1'b1;
      end
    end
  end

  assign bus.w_rd_en      = rd_en;
  assign bus.w_addr       = rd_addr;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;
  assign bus.result_class = class_reg;
  assign bus.score_o      = score_o_reg;
  assign bus.score_x      = score_x_reg;

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Directed bench for mlp_infer_ctrl: a 20-bit and a 16-bit accumulator instance share one weight ROM.
module tb_mlp_infer_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  mlp_infer_ctrl_if #(.ACC_W(20)) bus20 ();
  mlp_infer_ctrl_if #(.ACC_W(16)) bus16 ();

  mlp_infer_ctrl #(.ACC_W(20)) dut20 (.clk(clk), .rst(rst), .bus(bus20));
  mlp_infer_ctrl #(.ACC_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  logic signed [7:0] rom [256];

  always @(posedge clk) begin
    if (bus20.w_rd_en) bus20.w_data <= rom[bus20.w_addr];
    if (bus16.w_rd_en) bus16.w_data <= rom[bus16.w_addr];
  end

  int n_pass = 0;
  int n_total = 0;
  int first_done, last_done, n_done, busy_bad;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic s, input logic [15:0] f);
    bus20.start = s;  bus16.start = s;
    bus20.in_flags = f;  bus16.in_flags = f;
  endtask

  task automatic fill_uniform(input logic signed [7:0] hb, input logic signed [7:0] hw,
                              input logic signed [7:0] ob0, input logic signed [7:0] ow0,
                              input logic signed [7:0] ob1, input logic signed [7:0] ow1);
    for (int a = 0; a < 256; a++) rom[a] = 8'sd0;
    for (int h = 0; h < 8; h++) begin
      rom[h*17] = hb;
      for (int i = 0; i < 16; i++) rom[h*17 + 1 + i] = hw;
    end
    rom[136] = ob0;
    rom[145] = ob1;
    for (int j = 0; j < 8; j++) begin
      rom[137 + j] = ow0;
      rom[146 + j] = ow1;
    end
  endtask

  // One inference; cycle 0 is the cycle start is presented, sampling on negedges.
  task automatic run(input logic [15:0] flags, input logic [15:0] flags_mid, input int window,
                     input bit pulses, input bit restart, input int rst_cyc);
    logic s;
    logic [15:0] f;
    first_done = -1; last_done = -1; n_done = 0; busy_bad = 0;
    f = flags;
    @(negedge clk);
    drive(1'b1, f);
    for (int cyc = 1; cyc <= window; cyc++) begin
      @(negedge clk);
      if (bus20.done) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
        last_done = cyc;
      end
      if (rst_cyc == 0 && first_done < 0 && cyc < 176 && !bus20.busy) busy_bad++;
      s = (pulses && (cyc == 5 || cyc == 60)) || (restart && bus20.done && n_done == 1);
      if (cyc == 3) f = flags_mid;
      drive(s, f);
      if (rst_cyc != 0 && cyc == rst_cyc) rst = 1'b0;
      if (rst_cyc != 0 && cyc == rst_cyc + 2) rst = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic signed [63:0] so,
                              input logic signed [63:0] sx, input logic signed [63:0] cls);
    check({tag, "_latency"}, first_done, 176);
    check({tag, "_ndone"}, n_done, 1);
    check({tag, "_score_o"}, bus20.score_o, so);
    check({tag, "_score_x"}, bus20.score_x, sx);
    check({tag, "_class"}, bus20.result_class, cls);
    $display("%s: lat=%0d class=%0d score_o=%0d score_x=%0d", tag, first_done,
             bus20.result_class, bus20.score_o, bus20.score_x);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 16'h0000);
    bus20.w_data = '0;
    bus16.w_data = '0;
    fill_uniform(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    check("rst_busy", bus20.busy, 0);
    check("rst_done", bus20.done, 0);
    check("rst_class", bus20.result_class, 0);
    check("rst_score_o", bus20.score_o, 0);
    check("rst_score_x", bus20.score_x, 0);
    check("rst_w_rd_en", bus20.w_rd_en, 0);
    check("rst_w_addr", bus20.w_addr, 0);
    $display("reset: busy=%0d done=%0d class=%0d", bus20.busy, bus20.done, bus20.result_class);
    rst = 1'b1;
    @(negedge clk);

    // Bias-only network, no flags set.
    fill_uniform(0, 0, 5, 0, 3, 0);
    run(16'h0000, 16'h0000, 180, 0, 0, 0);
    check_result("bias_only", 5, 3, 1);
    check("bias_only_busy_held", busy_bad, 0);
    check("bias_only_busy_after", bus20.busy, 0);

    // Uniform gated sums: act = (40+160)>>>2 = 50.
    fill_uniform(40, 10, 0, 1, 0, 2);
    run(16'hFFFF, 16'hFFFF, 180, 0, 0, 0);
    check_result("uniform", 400, 800, 2);

    // Address-dependent ROM: act[h] = h+4, score_o = 2 + sum j*(j+4), score_x = 100 - sum(h+4).
    for (int a = 0; a < 256; a++) rom[a] = 8'sd0;
    for (int h = 0; h < 8; h++) begin
      rom[h*17] = 8'(4 * h);
      for (int i = 0; i < 16; i++) rom[h*17 + 1 + i] = 8'(i + 1);
    end
    rom[136] = 8'sd2;
    rom[145] = 8'sd100;
    for (int j = 0; j < 8; j++) begin
      rom[137 + j] = 8'(j);
      rom[146 + j] = -8'sd1;
    end
    run(16'h8001, 16'h8001, 180, 0, 0, 0);
    check_result("pattern", 254, 40, 1);

    fill_uniform(0, 0, 7, 0, 7, 0);
    run(16'hFFFF, 16'hFFFF, 180, 0, 0, 0);
    check_result("equal", 7, 7, 0);

    fill_uniform(0, 0, -1, 0, -1, 0);
    run(16'h0000, 16'h0000, 180, 0, 0, 0);
    check_result("negative", -1, -1, 0);

    // Activations clamp to 127; the 16-bit instance saturates its output sums.
    fill_uniform(127, 127, 0, 127, 0, -127);
    run(16'hFFFF, 16'hFFFF, 180, 0, 0, 0);
    check_result("sat20", 129032, -129032, 1);
    check("sat16_score_o", bus16.score_o, 32767);
    check("sat16_score_x", bus16.score_x, -32768);
    check("sat16_class", bus16.result_class, 1);
    $display("sat16: class=%0d score_o=%0d score_x=%0d", bus16.result_class, bus16.score_o,
             bus16.score_x);

    // Starts while busy ignored; flags changed mid-run ignored (0x00FF gives act=30).
    fill_uniform(40, 10, 0, 1, 0, 2);
    run(16'h00FF, 16'hFFFF, 400, 1, 0, 0);
    check_result("protocol", 240, 480, 2);

    // Start on the done cycle is accepted and latches the new flags.
    run(16'h00FF, 16'hFFFF, 360, 0, 1, 0);
    check("b2b_ndone", n_done, 2);
    check("b2b_second_done", last_done, 352);
    check("b2b_score_o", bus20.score_o, 400);
    check("b2b_score_x", bus20.score_x, 800);
    $display("b2b: dones=%0d last=%0d score_o=%0d", n_done, last_done, bus20.score_o);

    // Reset mid-run: no done, everything cleared.
    run(16'h00FF, 16'h00FF, 200, 0, 0, 90);
    check("rst_mid_ndone", n_done, 0);
    check("rst_mid_busy", bus20.busy, 0);
    check("rst_mid_class", bus20.result_class, 0);
    check("rst_mid_score_o", bus20.score_o, 0);
    check("rst_mid_score_x", bus20.score_x, 0);
    $display("rst_mid: dones=%0d busy=%0d score_o=%0d", n_done, bus20.busy, bus20.score_o);

    run(16'h00FF, 16'h00FF, 180, 0, 0, 0);
    check_result("after_rst", 240, 480, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
